mc_req_queue: RTL

- Synthesizable, parametrised successor to the behavioural memory-controller request queue.
- Accepts CPU memory requests (operation + address) through a valid/ready handshake and holds them in an in-order circular buffer of DEPTH entries.
- Each request retires at the head no earlier than SERVICE_LAT cycles after acceptance; retirement uses valid/ready with backpressure.
- Sits between the trace/request source and the DRAM command scheduler. Also reports occupancy, flush and an idle-timeout indication for end-of-run detection.

---
 rtl/mc_pkg.sv | 21 ++
 rtl/mc_req_queue_if.sv | 24 ++
 rtl/mc_ring_buf.sv | 63 ++++++
 rtl/mc_req_queue.sv | 109 ++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and default sizing for the memory-controller request queue.
package mc_pkg;

    localparam int MC_DEPTH       = 16;
    localparam int MC_ADDR_W      = 33;
    localparam int MC_OP_W        = 2;
    localparam int MC_SERVICE_LAT = 100;
    localparam int MC_IDLE_LIMIT  = 101;

    typedef enum logic [MC_OP_W-1:0] {
        READ   = 2'd0,
        WRITE  = 2'd1,
        IFETCH = 2'd2
    } op_e;

    typedef struct packed {
        op_e                  op;
        logic [MC_ADDR_W-1:0] addr;
    } mc_req_t;

endpackage

// File: rtl/mc_req_queue_if.sv
// Request-in / retire-out handshake bundle between the request source, the queue and the scheduler.
interface mc_req_queue_if #(
    parameter int ADDR_W = mc_pkg::MC_ADDR_W,
    parameter int OP_W   = mc_pkg::MC_OP_W
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [ADDR_W-1:0] in_addr;
    logic              out_valid;
    logic              out_ready;
    logic [OP_W-1:0]   out_op;
    logic [ADDR_W-1:0] out_addr;

    modport slave (
        input  in_valid, in_op, in_addr, out_ready,
        output in_ready, out_valid, out_op, out_addr
    );

    modport master (
        output in_valid, in_op, in_addr, out_ready,
        input  in_ready, out_valid, out_op, out_addr
    );
endinterface

// File: rtl/mc_ring_buf.sv
// In-order circular buffer of DEPTH payload slots with head/tail/count tracking.
module mc_ring_buf #(
    parameter int  DEPTH = 16,
    parameter type T     = logic,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  T                 wr_data,
    input  logic             rd_en,
    output T                 rd_data,
    output logic [PTR_W-1:0] head_ptr,
    output logic [PTR_W-1:0] tail_ptr,
    output logic [CNT_W-1:0] count
);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (wr_en) tail_reg <= wrap_inc(tail_reg);
            if (rd_en) head_reg <= wrap_inc(head_reg);
            if (wr_en && !rd_en)
                count_reg <= count_reg + CNT_W'(1);
            else if (!wr_en && rd_en)
                count_reg <= count_reg - CNT_W'(1);
        end
    end

    // Slots are cleared on reset so the head fields read back as zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en && !flush) begin
            mem[tail_reg] <= wr_data;
        end
    end

    assign rd_data  = mem[head_reg];
    assign head_ptr = head_reg;
    assign tail_ptr = tail_reg;
    assign count    = count_reg;

endmodule

// File: rtl/mc_req_queue.sv
// Memory-controller request queue: in-order buffer where each request becomes
// retirable SERVICE_LAT cycles after acceptance; also reports occupancy and idle timeout.
module mc_req_queue
    import mc_pkg::*;
#(
    parameter int  DEPTH       = MC_DEPTH,
    parameter int  ADDR_W      = MC_ADDR_W,
    parameter int  OP_W        = MC_OP_W,
    parameter int  SERVICE_LAT = MC_SERVICE_LAT,
    parameter int  IDLE_LIMIT  = MC_IDLE_LIMIT,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_req_queue_if.slave    bus,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             idle
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int AGE_W  = $clog2(SERVICE_LAT + 1);
    localparam int IDLE_W = $clog2(IDLE_LIMIT + 1);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr;
    } payload_t;

    payload_t                    wr_data;
    payload_t                    head_data;
    logic [PTR_W-1:0]            head_ptr;
    logic [PTR_W-1:0]            tail_ptr;
    logic                        accept;
    logic                        retire;
    logic [DEPTH-1:0][AGE_W-1:0] age_vec;
    logic [IDLE_W-1:0]           idle_cnt_reg;

    // in_ready depends only on the registered count, so full-plus-retire never bypasses.
    assign bus.in_ready  = (count < CNT_W'(DEPTH));
    assign accept        = bus.in_valid && bus.in_ready && !flush;
    assign bus.out_valid = (count != '0) && (age_vec[head_ptr] == AGE_W'(SERVICE_LAT));
    assign retire        = bus.out_valid && bus.out_ready && !flush;
    assign wr_data       = {bus.in_op, bus.in_addr};
    assign bus.out_op    = head_data.op;
    assign bus.out_addr  = head_data.addr;

    mc_ring_buf #(
        .DEPTH (DEPTH),
        .T     (payload_t)
    ) u_ring (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .wr_en    (accept),
        .wr_data  (wr_data),
        .rd_en    (retire),
        .rd_data  (head_data),
        .head_ptr (head_ptr),
        .tail_ptr (tail_ptr),
        .count    (count)
    );

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        localparam logic [CNT_W-1:0] SLOT    = CNT_W'(gi);
        localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

        logic [CNT_W-1:0] offset;
        logic             occupied;
        logic [AGE_W-1:0] age_reg;

        // Distance from head modulo DEPTH; the slot is live when it lies within count.
        assign offset   = SLOT - CNT_W'(head_ptr) + ((SLOT < CNT_W'(head_ptr)) ? DEPTH_C : '0);
        assign occupied = (offset < count);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                age_reg <= '0;
            else if (flush || (accept && tail_ptr == PTR_W'(gi)))
                age_reg <= '0;
            else if (occupied && age_reg < AGE_W'(SERVICE_LAT))
                age_reg <= age_reg + AGE_W'(1);
        end

        assign age_vec[gi] = age_reg;
    end

    // The idle counter deliberately ignores flush; only traffic or occupancy clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt_reg <= '0;
        else if (accept || count != '0)
            idle_cnt_reg <= '0;
        else if (idle_cnt_reg != IDLE_W'(IDLE_LIMIT))
            idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
    end

    assign idle = (idle_cnt_reg == IDLE_W'(IDLE_LIMIT));

    a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
        count <= CNT_W'(DEPTH));

    a_no_accept_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(accept && count == CNT_W'(DEPTH)));

    a_stall_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready && !flush) |=> ($stable(bus.out_op) && $stable(bus.out_addr)));

endmodule
